// File: rtl/key_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_filter_pkg
//  Description : Shared state encoding for the multi-channel key filter.
//  Revision    : 1.0 - initial release
// ============================================================================
package key_filter_pkg;

  // Width of the per-channel state register
  localparam int STATE_W = 2;

  // Per-channel debounce / hold state
  typedef enum logic [STATE_W-1:0] {
    IDLE        = 2'd0,
    FILTER_DOWN = 2'd1,
    DOWN        = 2'd2,
    FILTER_UP   = 2'd3
  } key_fsm_e;

endpackage
`default_nettype wire

// File: rtl/key_filter_ch.sv
`default_nettype none
// ============================================================================
//  Module      : key_filter_ch
//  Description : One key channel: 2-FF synchroniser, debounce FSM, long-press
//                and auto-repeat timing. All event outputs are registered
//                single-cycle pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_filter_ch
  import key_filter_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 1_000_000,
  parameter int LONG_CNT     = 50_000_000,
  parameter int REPEAT_CNT   = 10_000_000,
  parameter int REPEAT_EN    = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_state,
  output logic key_press_flag,
  output logic key_release_flag,
  output logic key_long_flag,
  output logic key_repeat_flag
);

  // Level seen on the pin when the key is not pressed
  localparam logic REL_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam int HOLD_W = $clog2(LONG_CNT + 1);
  localparam int REP_W  = $clog2(REPEAT_CNT + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CNT - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CNT - 1);

  logic [1:0]        sync_q, sync_d;
  key_fsm_e          state_q, state_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
  logic              long_done_q, long_done_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              repeat_q, repeat_d;
  logic              pressed;

  // Only the second synchroniser stage feeds decisions
  assign pressed = sync_q[1] ^ REL_LVL;

  // Next-state, counter and event-pulse logic for the channel
  always_comb begin
    sync_d      = {sync_q[0], key_in};
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    long_done_d = long_done_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    repeat_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d   = FILTER_DOWN;
          deb_cnt_d = '0;
        end
      end

      FILTER_DOWN: begin
        if (!pressed) begin
          // Bounce: drop back without any event
          state_d = IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = DOWN;
          press_d     = 1'b1;
          level_d     = ~REL_LVL;
          hold_cnt_d  = '0;
          rep_cnt_d   = '0;
          long_done_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end

      DOWN: begin
        if (!long_done_q) begin
          // Counts up to LONG_CNT and then stays there (saturation)
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          if (hold_cnt_q == LONG_LAST) begin
            long_d      = 1'b1;
            long_done_d = 1'b1;
            rep_cnt_d   = '0;
          end
        end else if (REPEAT_EN != 0) begin
          if (rep_cnt_q == REP_LAST) begin
            rep_cnt_d = '0;
            repeat_d  = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
        end
        if (!pressed) begin
          state_d   = FILTER_UP;
          deb_cnt_d = '0;
        end
      end

      FILTER_UP: begin
        // Hold and repeat timing are frozen while a release is being qualified
        if (pressed) begin
          state_d = DOWN;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
          level_d   = REL_LVL;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and counter registers with synchronous reset to the released level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= {REL_LVL, REL_LVL};
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      rep_cnt_q   <= '0;
      long_done_q <= 1'b0;
      level_q     <= REL_LVL;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  assign key_state        = level_q;
  assign key_press_flag   = press_q;
  assign key_release_flag = release_q;
  assign key_long_flag    = long_q;
  assign key_repeat_flag  = repeat_q;

endmodule
`default_nettype wire

// File: rtl/key_filter_multi.sv
`default_nettype none
// ============================================================================
//  Module      : key_filter_multi
//  Description : N_KEYS independent key filters (debounce, press/release,
//                long-press and auto-repeat events) behind one interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_filter_multi
  import key_filter_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int DEBOUNCE_CNT = 1_000_000,
  parameter int LONG_CNT     = 50_000_000,
  parameter int REPEAT_CNT   = 10_000_000,
  parameter int REPEAT_EN    = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press_flag,
  output logic [N_KEYS-1:0] key_release_flag,
  output logic [N_KEYS-1:0] key_long_flag,
  output logic [N_KEYS-1:0] key_repeat_flag
);

  // One self-contained filter per key; outputs are simply gathered into vectors
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_filter_ch #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .LONG_CNT     (LONG_CNT),
      .REPEAT_CNT   (REPEAT_CNT),
      .REPEAT_EN    (REPEAT_EN),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk              (clk),
      .rst              (rst),
      .key_in           (key_in[i]),
      .key_state        (key_state[i]),
      .key_press_flag   (key_press_flag[i]),
      .key_release_flag (key_release_flag[i]),
      .key_long_flag    (key_long_flag[i]),
      .key_repeat_flag  (key_repeat_flag[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_key_filter_multi.sv
`timescale 1ns/1ps
module tb_key_filter_multi;

  localparam int N   = 4;
  localparam int D   = 16;
  localparam int L   = 200;
  localparam int R   = 50;
  localparam int LAT = D + 3;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;
  localparam int K_REPEAT  = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] key_in = '1;

  logic [N-1:0] key_state, key_press_flag, key_release_flag, key_long_flag, key_repeat_flag;
  logic [N-1:0] st2, pr2, rl2, lg2, rp2;

  key_filter_multi #(
    .N_KEYS(N), .DEBOUNCE_CNT(D), .LONG_CNT(L), .REPEAT_CNT(R),
    .REPEAT_EN(1), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_state(key_state), .key_press_flag(key_press_flag),
    .key_release_flag(key_release_flag), .key_long_flag(key_long_flag),
    .key_repeat_flag(key_repeat_flag)
  );

  key_filter_multi #(
    .N_KEYS(N), .DEBOUNCE_CNT(D), .LONG_CNT(L), .REPEAT_CNT(R),
    .REPEAT_EN(0), .ACTIVE_LOW(1)
  ) dut_norep (
    .clk(clk), .rst(rst), .key_in(key_in),
    .key_state(st2), .key_press_flag(pr2),
    .key_release_flag(rl2), .key_long_flag(lg2),
    .key_repeat_flag(rp2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int lo;
    int hi;
    int kind;
    int ch;
  } exp_t;
  exp_t sb[$];

  task automatic sb_push(input int lo, input int hi, input int kind, input int ch);
    exp_t e;
    e.lo = lo; e.hi = hi; e.kind = kind; e.ch = ch;
    sb.push_back(e);
  endtask

  function automatic string kname(input int k);
    case (k)
      K_PRESS:   return "press";
      K_RELEASE: return "release";
      K_LONG:    return "long";
      default:   return "repeat";
    endcase
  endfunction

  bit           mon_en  = 1'b0;
  int           rep2    = 0;
  int           lng2    = 0;
  int           mis2    = 0;
  logic [N-1:0] fl [4];
  int           found;

  // Every observed flag must consume a matching pending expectation
  always @(negedge clk) begin
    if (mon_en) begin
      fl[0] = key_press_flag;
      fl[1] = key_release_flag;
      fl[2] = key_long_flag;
      fl[3] = key_repeat_flag;
      for (int k = 0; k < 4; k++) begin
        for (int c = 0; c < N; c++) begin
          if (fl[k][c]) begin
            found = -1;
            for (int i = 0; i < sb.size(); i++)
              if (found < 0 && sb[i].kind == k && sb[i].ch == c &&
                  cyc >= sb[i].lo && cyc <= sb[i].hi)
                found = i;
            chk(found >= 0, $sformatf("event %s ch%0d at cycle", kname(k), c),
                cyc, (found >= 0) ? sb[found].lo : -1);
            if (found >= 0) sb.delete(found);
          end
        end
      end
      if (rp2 != '0) rep2++;
      if (lg2 != '0) lng2++;
      if (pr2 != key_press_flag || rl2 != key_release_flag ||
          lg2 != key_long_flag || st2 != key_state)
        mis2++;
    end
  end

  task automatic drain(input string phase);
    chk(sb.size() == 0, {phase, " pending events"}, sb.size(), 0);
    foreach (sb[i])
      $display("  missing %s ch%0d in [%0d,%0d]", kname(sb[i].kind), sb[i].ch, sb[i].lo, sb[i].hi);
    sb.delete();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [N-1:0] keys;
    logic [N-1:0] exp_state;
  } vec_t;
  vec_t vecs[6];

  logic [N-1:0] prev;
  int t, p;

  initial begin
    vecs[0] = '{keys: 4'hF, exp_state: 4'hF};
    vecs[1] = '{keys: 4'hE, exp_state: 4'hE};
    vecs[2] = '{keys: 4'hA, exp_state: 4'hA};
    vecs[3] = '{keys: 4'h5, exp_state: 4'h5};
    vecs[4] = '{keys: 4'h0, exp_state: 4'h0};
    vecs[5] = '{keys: 4'hF, exp_state: 4'hF};

    // Reset state
    rst = 1'b1;
    key_in = '1;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    chk(key_state == 4'hF, "reset key_state", key_state, 4'hF);
    chk((key_press_flag | key_release_flag | key_long_flag | key_repeat_flag) == '0,
        "reset flags", key_press_flag | key_release_flag | key_long_flag | key_repeat_flag, 0);
    mon_en = 1'b1;

    // Table-driven level patterns
    prev = 4'hF;
    for (int i = 0; i < 6; i++) begin
      step(1);
      key_in = vecs[i].keys;
      t = cyc;
      for (int c = 0; c < N; c++) begin
        if (prev[c] && !vecs[i].keys[c]) sb_push(t + LAT, t + LAT, K_PRESS, c);
        if (!prev[c] && vecs[i].keys[c]) sb_push(t + LAT, t + LAT, K_RELEASE, c);
      end
      prev = vecs[i].keys;
      step(30);
      @(negedge clk);
      chk(key_state == vecs[i].exp_state, $sformatf("vector %0d key_state", i),
          key_state, vecs[i].exp_state);
    end
    drain("table");

    // Clean press on ch0
    step(1);
    key_in[0] = 1'b0;
    t = cyc;
    sb_push(t + LAT, t + LAT, K_PRESS, 0);
    step(50);
    chk(key_state == 4'hE, "clean hold key_state", key_state, 4'hE);
    step(50);
    key_in[0] = 1'b1;
    t = cyc;
    sb_push(t + LAT, t + LAT, K_RELEASE, 0);
    step(30);
    drain("clean press");

    // Bounce on ch1
    for (int i = 0; i < 10; i++) begin
      key_in[1] = ~key_in[1];
      step($urandom_range(1, 15));
    end
    key_in[1] = 1'b0;
    t = cyc;
    sb_push(t + LAT, t + LAT, K_PRESS, 1);
    step(40);
    chk(key_state == 4'hD, "bounce key_state", key_state, 4'hD);
    key_in[1] = 1'b1;
    t = cyc;
    sb_push(t + LAT, t + LAT, K_RELEASE, 1);
    step(30);
    drain("bounce");

    // Long hold on ch2 with repeats
    key_in[2] = 1'b0;
    t = cyc;
    p = t + LAT;
    sb_push(p, p, K_PRESS, 2);
    sb_push(p + L, p + L, K_LONG, 2);
    sb_push(p + L + R, p + L + R, K_REPEAT, 2);
    sb_push(p + L + 2 * R, p + L + 2 * R, K_REPEAT, 2);
    sb_push(p + L + 3 * R, p + L + 3 * R, K_REPEAT, 2);
    step(400);
    key_in[2] = 1'b1;
    t = cyc;
    sb_push(t + LAT, t + LAT, K_RELEASE, 2);
    step(30);
    drain("long hold");
    chk(lng2 == 1, "no-repeat instance long count", lng2, 1);
    chk(rep2 == 0, "no-repeat instance repeat count", rep2, 0);

    // Short glitch during a hold on ch2
    key_in[2] = 1'b0;
    t = cyc;
    p = t + LAT;
    sb_push(p, p, K_PRESS, 2);
    step(LAT + 100);
    key_in[2] = 1'b1;
    step(5);
    key_in[2] = 1'b0;
    sb_push(p + L + 4, p + L + 8, K_LONG, 2);
    step(p + 230 - cyc);
    key_in[2] = 1'b1;
    t = cyc;
    sb_push(t + LAT, t + LAT, K_RELEASE, 2);
    step(30);
    drain("glitch");

    // Simultaneous press on ch0 and ch3
    key_in = 4'b0110;
    t = cyc;
    sb_push(t + LAT, t + LAT, K_PRESS, 0);
    sb_push(t + LAT, t + LAT, K_PRESS, 3);
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    chk(key_press_flag == 4'b1001, "simultaneous press vector", key_press_flag, 4'b1001);
    step(20);
    key_in = 4'hF;
    t = cyc;
    sb_push(t + LAT, t + LAT, K_RELEASE, 0);
    sb_push(t + LAT, t + LAT, K_RELEASE, 3);
    step(30);
    drain("simultaneous");

    // Reset while ch0 is held down
    key_in[0] = 1'b0;
    t = cyc;
    sb_push(t + LAT, t + LAT, K_PRESS, 0);
    step(40);
    chk(key_state == 4'hE, "pre-reset key_state", key_state, 4'hE);
    rst = 1'b1;
    key_in[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(key_state == 4'hF, "mid-press reset key_state", key_state, 4'hF);
    chk((key_press_flag | key_release_flag | key_long_flag | key_repeat_flag) == '0,
        "mid-press reset flags",
        key_press_flag | key_release_flag | key_long_flag | key_repeat_flag, 0);
    rst = 1'b0;
    step(40);
    drain("reset mid-press");
    key_in[0] = 1'b0;
    t = cyc;
    sb_push(t + LAT, t + LAT, K_PRESS, 0);
    step(30);
    chk(key_state == 4'hE, "post-reset press key_state", key_state, 4'hE);
    key_in[0] = 1'b1;
    t = cyc;
    sb_push(t + LAT, t + LAT, K_RELEASE, 0);
    step(30);
    drain("post-reset press");

    chk(lng2 == 2, "no-repeat instance total long count", lng2, 2);
    chk(rep2 == 0, "no-repeat instance total repeat count", rep2, 0);
    chk(mis2 == 0, "no-repeat instance divergence cycles", mis2, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
